// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg
//   Shared definitions for the ADC SPI reader: the frame FSM state type,
//   default width/timing constants and the overrun counter width.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHIFT   = 2'd2
  } adc_spi_state_t;

  localparam int DEF_DATA_WIDTH  = 24;  // bits per ADC sample
  localparam int DEF_CONV_CYCLES = 80;  // clk cycles CNV is held high
  localparam int DEF_SCK_HALF    = 2;   // clk cycles per SCK half-period (1..255)
  localparam int OVR_CNT_W       = 16;  // width of the optional overrun counter

endpackage

// File: rtl/adc_spi_sck_gen.sv
// adc_spi_sck_gen
//   SPI clock generator for the shift phase. While en is high it divides clk
//   by SCK_HALF to produce a CPOL=0 sck that starts low, and reports the
//   cycles on which sck is about to rise or fall. Everything returns to the
//   idle state (sck low, counters zero) as soon as en drops.
// Ports:
//   clk, resetn : system clock, asynchronous active-low reset
//   en          : run the divider (high for the whole shift phase)
//   sck         : SPI clock output
//   rise, fall  : strobes, high on the clk cycle whose edge drives sck high/low
//   done        : high while the final (EDGES-th) sck pulse is in progress
module adc_spi_sck_gen #(
  parameter int SCK_HALF = 2,
  parameter int EDGES    = 24
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall,
  output logic done
);

  localparam int EW = $clog2(EDGES + 1);

  logic [7:0]    div_cnt_reg;
  logic          sck_reg;
  logic [EW-1:0] fall_cnt_reg;
  logic          tick;

  // tick marks the last clk cycle of an sck half-period
  assign tick = en && (div_cnt_reg == 8'(SCK_HALF - 1));
  assign rise = tick && !sck_reg;
  assign fall = tick && sck_reg;
  // all earlier pulses have completed, so the current one is the last
  assign done = en && (fall_cnt_reg == EW'(EDGES - 1));
  assign sck  = sck_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_reg  <= '0;
      sck_reg      <= 1'b0;
      fall_cnt_reg <= '0;
    end else if (!en) begin
      div_cnt_reg  <= '0;
      sck_reg      <= 1'b0;
      fall_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= tick ? 8'd0 : div_cnt_reg + 8'd1;
      if (tick) begin
        sck_reg <= !sck_reg;
      end
      if (fall) begin
        fall_cnt_reg <= fall_cnt_reg + EW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// adc_spi_reader
//   Drives a conversion-start / SPI-readout cycle on a serial ADC for every
//   accepted trigger pulse and presents each captured sample on an
//   AXI-Stream style output with a one-entry holding register.
// Ports:
//   clk, resetn        : system clock (rising edge), asynchronous active-low reset
//   trigger            : single-cycle start pulse
//   cnv                : ADC conversion start, high for CONV_CYCLES cycles
//   cs_n, sck, sdo     : SPI chip select (active low), clock (CPOL=0), data in (MSB first)
//   m_axis_tdata/tvalid/tready : captured sample output
//   busy               : a frame is in progress
//   overrun            : sticky flag, a trigger was ignored or a sample was dropped
//   overrun_count      : (only with ADC_SPI_READER_OVERRUN_CNT_EN defined)
//                        saturating count of overrun events
// Build option:
//   ADC_SPI_READER_OVERRUN_CNT_EN adds the overrun_count output and its counter.
module adc_spi_reader
  import adc_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int SCK_HALF    = DEF_SCK_HALF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  trigger,
  output logic                  cnv,
  output logic                  cs_n,
  output logic                  sck,
  input  logic                  sdo,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun
`ifdef ADC_SPI_READER_OVERRUN_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0]  overrun_count
`endif
);

  localparam int CW = $clog2(CONV_CYCLES + 1);

  adc_spi_state_t        state_reg, state_next;
  logic [CW-1:0]         conv_cnt_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] tdata_reg;
  logic                  tvalid_reg;
  logic                  overrun_reg;

  logic sck_rise, sck_fall, sck_done;
  logic conv_done, shift_exit, accept, drop, trig_ignored;

  adc_spi_sck_gen #(
    .SCK_HALF (SCK_HALF),
    .EDGES    (DATA_WIDTH)
  ) u_sck_gen (
    .clk    (clk),
    .resetn (resetn),
    .en     (state_reg == SHIFT),
    .sck    (sck),
    .rise   (sck_rise),
    .fall   (sck_fall),
    .done   (sck_done)
  );

  assign conv_done    = (conv_cnt_reg == CW'(CONV_CYCLES - 1));
  // the falling edge of the final sck pulse ends the frame
  assign shift_exit   = sck_fall && sck_done;
  // the holding register can take a new sample if empty or being drained now
  assign accept       = !tvalid_reg || m_axis_tready;
  assign drop         = shift_exit && !accept;
  assign trig_ignored = trigger && busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnv        = 1'b0;
    cs_n       = 1'b1;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (trigger) begin
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        cnv = 1'b1;
        if (conv_done) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        cs_n = 1'b0;
        if (shift_exit) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      conv_cnt_reg <= '0;
      shift_reg    <= '0;
      tdata_reg    <= '0;
      tvalid_reg   <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      conv_cnt_reg <= (state_reg == CONVERT) ? conv_cnt_reg + CW'(1) : '0;

      // sdo is taken on the cycle that drives sck high, MSB first
      if (sck_rise) begin
        shift_reg <= {shift_reg[DATA_WIDTH-2:0], sdo};
      end

      // a reload wins over the handshake that empties the register
      if (shift_exit && accept) begin
        tdata_reg  <= shift_reg;
        tvalid_reg <= 1'b1;
      end else if (tvalid_reg && m_axis_tready) begin
        tvalid_reg <= 1'b0;
      end

      if (drop || trig_ignored) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign overrun       = overrun_reg;

`ifdef ADC_SPI_READER_OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] ovr_cnt_reg;
  logic [OVR_CNT_W:0]   ovr_sum;

  // a dropped sample and an ignored trigger in the same cycle count as two
  assign ovr_sum = {1'b0, ovr_cnt_reg} + (OVR_CNT_W + 1)'(drop) + (OVR_CNT_W + 1)'(trig_ignored);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovr_cnt_reg <= '0;
    end else if (ovr_sum[OVR_CNT_W]) begin
      ovr_cnt_reg <= '1;
    end else begin
      ovr_cnt_reg <= ovr_sum[OVR_CNT_W-1:0];
    end
  end

  assign overrun_count = ovr_cnt_reg;
`endif

endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader
//   Directed self-checking bench for adc_spi_reader with default parameters
//   (24-bit samples, 80-cycle conversion, SCK half-period of 2 clk cycles).
//   Build with ADC_SPI_READER_OVERRUN_CNT_EN to also exercise overrun_count.
module tb_adc_spi_reader;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          trigger = 1'b0;
  logic          cnv, cs_n, sck;
  logic          sdo = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          busy, overrun;
`ifdef ADC_SPI_READER_OVERRUN_CNT_EN
  logic [15:0]   overrun_count;
`endif

  int total = 0;
  int bad   = 0;

  // word the ADC model serialises on the next frame
  logic [DW-1:0] adc_word = '0;
  int            bit_idx  = 0;
  logic          prev_sck = 1'b0;

  adc_spi_reader dut (
    .clk           (clk),
    .resetn        (resetn),
    .trigger       (trigger),
    .cnv           (cnv),
    .cs_n          (cs_n),
    .sck           (sck),
    .sdo           (sdo),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .overrun       (overrun)
`ifdef ADC_SPI_READER_OVERRUN_CNT_EN
    ,
    .overrun_count (overrun_count)
`endif
  );

  always #5 clk = ~clk;

  // ADC model: MSB presented when cs_n falls, next bit after each sck fall
  always @(negedge clk) begin
    if (cs_n) begin
      bit_idx = 0;
      sdo     = adc_word[DW-1];
    end else begin
      if (prev_sck && !sck) begin
        bit_idx = bit_idx + 1;
      end
      if (bit_idx < DW) begin
        sdo = adc_word[DW-1-bit_idx];
      end
    end
    prev_sck = sck;
  end

  // leaves the bench at a negedge with reset released
  task automatic do_reset();
    trigger = 1'b0;
    resetn  = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // trigger is high for cycle 0; returns at the sampling point of cycle 1
  task automatic start_frame();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    trigger = 1'b0;
    @(negedge clk);
    total++; if (cnv !== 1'b0) begin bad++; $display("FAIL reset_cnv got=%b want=0", cnv); end
    total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n got=%b want=1", cs_n); end
    total++; if (sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", sck); end
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); end
    total++; if (m_axis_tdata !== 24'h000000) begin bad++; $display("FAIL reset_tdata got=%h want=000000", m_axis_tdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    $display("test_reset done");
  endtask

  task automatic test_frame_timing();
    int   shown = 0;
    int   rises = 0;
    logic last_sck = 1'b0;
    logic [4:0] exp_v, obs_v;
    do_reset();
    m_axis_tready = 1'b1;
    adc_word      = 24'hA5C3F1;
    start_frame();
    for (int k = 1; k <= 182; k++) begin
      exp_v[4] = (k >= 1 && k <= 80);                                   // cnv
      exp_v[3] = !(k >= 81 && k <= 176);                                // cs_n
      exp_v[2] = (k >= 81 && k <= 176) && ((((k - 81) / 2) % 2) == 1);  // sck
      exp_v[1] = (k <= 176);                                            // busy
      exp_v[0] = (k == 177);                                            // tvalid
      obs_v    = {cnv, cs_n, sck, busy, m_axis_tvalid};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        if (shown < 5) $display("FAIL timing cycle=%0d got{cnv,cs_n,sck,busy,tvalid}=%b want=%b", k, obs_v, exp_v);
        shown++;
      end
      if (sck === 1'b1 && last_sck === 1'b0) rises++;
      last_sck = sck;
      if (k == 177) begin
        total++;
        if (m_axis_tdata !== 24'hA5C3F1) begin bad++; $display("FAIL timing_tdata got=%h want=a5c3f1", m_axis_tdata); end
      end
      @(negedge clk);
    end
    total++; if (rises != 24) begin bad++; $display("FAIL timing_sck_pulses got=%0d want=24", rises); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL timing_overrun got=%b want=0", overrun); end
    $display("test_frame_timing done: sample=%h pulses=%0d", 24'hA5C3F1, rises);
  endtask

  task automatic test_ignored_trigger();
    do_reset();
    m_axis_tready = 1'b1;
    adc_word      = 24'h3C5A96;
    start_frame();
    for (int k = 1; k <= 178; k++) begin
      if (k == 50) trigger = 1'b1;
      if (k == 51) trigger = 1'b0;
      if (k == 49) begin
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ignored_pre_overrun got=%b want=0", overrun); end
      end
      if (k == 51) begin
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ignored_overrun got=%b want=1", overrun); end
        total++; if (cnv !== 1'b1) begin bad++; $display("FAIL ignored_cnv got=%b want=1", cnv); end
      end
      if (k == 177) begin
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL ignored_tvalid got=%b want=1", m_axis_tvalid); end
        total++; if (m_axis_tdata !== 24'h3C5A96) begin bad++; $display("FAIL ignored_tdata got=%h want=3c5a96", m_axis_tdata); end
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL ignored_cs_n_end got=%b want=1", cs_n); end
      end
      if (k == 178) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignored_no_refire got=%b want=0", busy); end
      end
      @(negedge clk);
    end
    $display("test_ignored_trigger done");
  endtask

  task automatic test_exit_trigger();
    do_reset();
    m_axis_tready = 1'b1;
    adc_word      = 24'h0F1E2D;
    start_frame();
    for (int k = 1; k <= 179; k++) begin
      if (k == 176) trigger = 1'b1;
      if (k == 177) trigger = 1'b0;
      if (k == 175) begin
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL exit_pre_overrun got=%b want=0", overrun); end
      end
      if (k == 177) begin
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL exit_overrun got=%b want=1", overrun); end
        total++; if (m_axis_tdata !== 24'h0F1E2D) begin bad++; $display("FAIL exit_tdata got=%h want=0f1e2d", m_axis_tdata); end
      end
      if (k == 178 || k == 179) begin
        total++; if ({busy, cnv} !== 2'b00) begin bad++; $display("FAIL exit_no_start cycle=%0d got{busy,cnv}=%b want=00", k, {busy, cnv}); end
      end
      @(negedge clk);
    end
    $display("test_exit_trigger done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    m_axis_tready = 1'b1;
    adc_word      = 24'h123456;
    start_frame();
    for (int k = 1; k <= 356; k++) begin
      if (k == 178) begin trigger = 1'b1; adc_word = 24'h654321; end
      if (k == 179) trigger = 1'b0;
      if (k == 177) begin
        total++; if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 24'h123456}) begin
          bad++; $display("FAIL b2b_first got=%b/%h want=1/123456", m_axis_tvalid, m_axis_tdata);
        end
      end
      if (k == 179) begin
        total++; if (cnv !== 1'b1) begin bad++; $display("FAIL b2b_second_cnv got=%b want=1", cnv); end
      end
      if (k == 355) begin
        total++; if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 24'h654321}) begin
          bad++; $display("FAIL b2b_second got=%b/%h want=1/654321", m_axis_tvalid, m_axis_tdata);
        end
      end
      @(negedge clk);
    end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", overrun); end
    $display("test_back_to_back done");
  endtask

  task automatic test_backpressure();
    int hs = 0;
    do_reset();
    m_axis_tready = 1'b0;
    adc_word      = 24'h000001;
    start_frame();
    for (int k = 1; k <= 355; k++) begin
      if (k == 178) begin trigger = 1'b1; adc_word = 24'h000002; end
      if (k == 179) trigger = 1'b0;
      if (k == 177) begin
        total++; if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 24'h000001}) begin
          bad++; $display("FAIL bp_first got=%b/%h want=1/000001", m_axis_tvalid, m_axis_tdata);
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL bp_first_overrun got=%b want=0", overrun); end
      end
      if (k == 355) begin
        total++; if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 24'h000001}) begin
          bad++; $display("FAIL bp_held got=%b/%h want=1/000001", m_axis_tvalid, m_axis_tdata);
        end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun got=%b want=1", overrun); end
      end
      if (k < 355) @(negedge clk);
    end
    @(negedge clk);
    m_axis_tready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (m_axis_tvalid === 1'b1) hs++;
      @(negedge clk);
    end
    total++; if (hs != 1) begin bad++; $display("FAIL bp_handshakes got=%0d want=1", hs); end
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", m_axis_tvalid); end
    $display("test_backpressure done: handshakes=%0d", hs);
  endtask

  task automatic test_reset_mid_frame();
    int early_valid = 0;
    do_reset();
    m_axis_tready = 1'b1;
    adc_word      = 24'hFFFFFF;
    start_frame();
    for (int k = 1; k < 123; k++) @(negedge clk);
    // cycle 123: sck has just risen for bit 10 of the shift phase
    total++; if ({cs_n, sck} !== 2'b01) begin bad++; $display("FAIL mid_in_shift got{cs_n,sck}=%b want=01", {cs_n, sck}); end
    resetn = 1'b0;
    #1;
    total++; if ({cnv, cs_n, sck, busy, m_axis_tvalid, overrun} !== 6'b010000) begin
      bad++; $display("FAIL mid_reset_outputs got{cnv,cs_n,sck,busy,tvalid,overrun}=%b want=010000",
                      {cnv, cs_n, sck, busy, m_axis_tvalid, overrun});
    end
    total++; if (m_axis_tdata !== 24'h000000) begin bad++; $display("FAIL mid_reset_tdata got=%h want=000000", m_axis_tdata); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int j = 0; j < 60; j++) begin
      if (m_axis_tvalid !== 1'b0) early_valid++;
      @(negedge clk);
    end
    total++; if (early_valid != 0) begin bad++; $display("FAIL mid_partial_sample got=%0d want=0", early_valid); end
    adc_word = 24'h5AA5C3;
    start_frame();
    for (int k = 1; k < 177; k++) @(negedge clk);
    total++; if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 24'h5AA5C3}) begin
      bad++; $display("FAIL mid_recover got=%b/%h want=1/5aa5c3", m_axis_tvalid, m_axis_tdata);
    end
    $display("test_reset_mid_frame done");
  endtask

`ifdef ADC_SPI_READER_OVERRUN_CNT_EN
  task automatic test_overrun_count();
    do_reset();
    m_axis_tready = 1'b1;
    adc_word      = 24'hC0FFEE;
    total++; if (overrun_count !== 16'd0) begin bad++; $display("FAIL cnt_reset got=%0d want=0", overrun_count); end
    start_frame();
    for (int k = 1; k <= 178; k++) begin
      trigger = (k == 10 || k == 20 || k == 30);
      @(negedge clk);
    end
    trigger = 1'b0;
    total++; if (overrun_count !== 16'd3) begin bad++; $display("FAIL cnt_three got=%0d want=3", overrun_count); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL cnt_overrun got=%b want=1", overrun); end
    $display("test_overrun_count done: count=%0d", overrun_count);
  endtask
`endif

  initial begin
    test_reset();
    test_frame_timing();
    test_ignored_trigger();
    test_exit_trigger();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
`ifdef ADC_SPI_READER_OVERRUN_CNT_EN
    test_overrun_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
